gf_div8_seq: RTL and testbench

Sequential GF(2^8) divider computing q = n · d⁻¹ over the field generated by x^8 + x^4 + x^3 + x^2 + 1 (0x11D), the same field and bit ordering as the team's combinational GF(2^8) multiplier. It is the inverse-direction companion of that multiplier: given a product and one factor, it recovers the other factor. It uses one shared 8×8 GF multiplier, iterated over several cycles, behind valid/ready handshakes on both sides. It sits between a syndrome/ECC datapath and any consumer that needs field division.

---
 rtl/gf_div8_seq_if.sv | 23 ++
 rtl/gf_div8_seq.sv | 138 +++++++++++++
 tb/tb_gf_div8_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/gf_div8_seq_if.sv
// Handshake bundle between a GF(2^8) divider and its producer/consumer.
// slave  : divider side (accepts n/d, presents q/div_by_zero).
// master : environment side (drives operands, consumes the result).
interface gf_div8_seq_if;
    logic       in_valid;     // operand pair on n/d is valid
    logic       in_ready;     // divider can accept operands
    logic [7:0] n;            // dividend, bit i = coefficient of x^i
    logic [7:0] d;            // divisor, same ordering
    logic       out_valid;    // q / div_by_zero valid
    logic       out_ready;    // consumer accepts the result
    logic [7:0] q;            // quotient n * d^-1
    logic       div_by_zero;  // captured divisor was zero

    modport slave (
        input  in_valid, n, d, out_ready,
        output in_ready, out_valid, q, div_by_zero
    );

    modport master (
        output in_valid, n, d, out_ready,
        input  in_ready, out_valid, q, div_by_zero
    );
endinterface

// File: rtl/gf_div8_seq.sv
// Sequential GF(2^8) divider q = n * d^-1 (poly 0x11D) using one shared multiplier.
// Latency: 8 cycles from accept to out_valid; next accept no sooner than 10 cycles after.
// Backpressure: result held in DONE until out_ready; in_ready only while idle.
// Ports: clk, rst_n (async active-low), io (slave modport: in_valid/in_ready/n/d,
//        out_valid/out_ready/q/div_by_zero).
module gf_div8_seq #(
    parameter logic [7:0] POLY = 8'h1D
) (
    input  logic         clk,
    input  logic         rst_n,
    gf_div8_seq_if.slave io
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXP  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Shift-and-add carry-less multiply with reduction folded into each shift.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ POLY) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Squaring is linear over GF(2): spread bits to even positions, then fold
    // the high terms back down. With a constant POLY this is pure XOR logic.
    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        logic [14:0] w;
        w = 15'd0;
        for (int i = 0; i < 8; i++) begin
            w[2*i] = a[i];
        end
        for (int k = 14; k >= 8; k--) begin
            if (w[k]) begin
                w[k] = 1'b0;
                w    = w ^ (15'(POLY) << (k - 8));
            end
        end
        return w[7:0];
    endfunction

    state_t     state_q, state_d;
    logic [7:0] nr_q,   nr_d;
    logic [7:0] t_q,    t_d;
    logic [7:0] acc_q,  acc_d;
    logic [2:0] cnt_q,  cnt_d;
    logic [7:0] quot_q, quot_d;
    logic       dz_q,   dz_d;

    logic [7:0] t_sq;
    logic [7:0] mul_a;
    logic [7:0] mul_b;
    logic [7:0] mul_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            nr_q    <= 8'h00;
            t_q     <= 8'h00;
            acc_q   <= 8'h00;
            cnt_q   <= 3'd0;
            quot_q  <= 8'h00;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            nr_q    <= nr_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            dz_q    <= dz_d;
        end
    end

    // Single multiplier: (acc, t^2) while exponentiating, (nr, acc) for the final product.
    always_comb begin
        t_sq  = gf_sq(t_q);
        mul_a = nr_q;
        mul_b = acc_q;
        if (state_q == S_EXP) begin
            mul_a = acc_q;
            mul_b = t_sq;
        end
        mul_p = gf_mul(mul_a, mul_b);
    end

    always_comb begin
        state_d = state_q;
        nr_d    = nr_q;
        t_d     = t_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    nr_d    = io.n;
                    t_d     = io.d;
                    acc_d   = 8'h01;
                    dz_d    = (io.d == 8'h00);
                    cnt_d   = 3'd0;
                    state_d = S_EXP;
                end
            end
            S_EXP: begin
                // acc accumulates d^2 * d^4 * ... * d^128 = d^254 = d^-1.
                t_d   = t_sq;
                acc_d = mul_p;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) state_d = S_MUL;
            end
            S_MUL: begin
                quot_d  = mul_p;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (io.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign io.in_ready    = (state_q == S_IDLE);
    assign io.out_valid   = (state_q == S_DONE);
    assign io.q           = quot_q;
    assign io.div_by_zero = dz_q;

endmodule

// File: tb/tb_gf_div8_seq.sv
module tb_gf_div8_seq;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    gf_div8_seq_if ifc ();

    gf_div8_seq #(.POLY(8'h1D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Reference multiplier: full 15-bit carry-less product, then reduce by 0x11D.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (15'h11D << (k - 8));
        end
        return p[7:0];
    endfunction

    // Driver only: called at posedge+1, returns at posedge+1 of the first out_valid cycle.
    task automatic do_op(input logic [7:0] nn, input logic [7:0] dd, input bit poke,
                         output logic [7:0] qq, output logic dzz, output int lat,
                         output int acc_at);
        int guard;
        guard = 0;
        while (!ifc.in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        ifc.n = nn;
        ifc.d = dd;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        acc_at = cyc;
        ifc.in_valid = 1'b0;
        ifc.n = ~nn;
        ifc.d = ~dd;
        lat = 0;
        while (!ifc.out_valid && lat < 20) begin
            if (poke && lat == 3) begin
                ifc.in_valid = 1'b1;
                ifc.n = 8'h33;
                ifc.d = 8'h44;
            end else begin
                ifc.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        ifc.in_valid = 1'b0;
        qq  = ifc.q;
        dzz = ifc.div_by_zero;
        if (guard >= 40) lat = -1;
    endtask

    task automatic test_reset();
        logic [7:0] qq;
        logic       dzz;
        int         lat, acc_at;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        ifc.n = 8'h00;
        ifc.d = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", ifc.in_ready); end
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", ifc.out_valid); end
        tests++; if (ifc.q !== 8'h00) begin fails++; $display("FAIL reset_q got %h exp 00", ifc.q); end
        tests++; if (ifc.div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b exp 0", ifc.div_by_zero); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got %b exp 1", ifc.in_ready); end
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL idle_out_valid got %b exp 0", ifc.out_valid); end
        // in_valid pulsed mid-operation with 0x33/0x44 must not disturb 1/2.
        do_op(8'h01, 8'h02, 1'b1, qq, dzz, lat, acc_at);
        tests++; if (qq !== 8'h8E) begin fails++; $display("FAIL busy_ignore_q got %h exp 8e", qq); end
        tests++; if (lat !== 8) begin fails++; $display("FAIL busy_ignore_lat got %0d exp 8", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] vn [4] = '{8'h01, 8'h02, 8'h04, 8'h05};
        logic [7:0] vd [4] = '{8'h02, 8'h02, 8'h02, 8'h01};
        logic [7:0] vq [4] = '{8'h8E, 8'h01, 8'h02, 8'h05};
        logic [7:0] qq;
        logic       dzz;
        int         lat, acc_at;
        for (int i = 0; i < 4; i++) begin
            do_op(vn[i], vd[i], 1'b0, qq, dzz, lat, acc_at);
            tests++; if (qq !== vq[i]) begin fails++; $display("FAIL basic%0d_q got %h exp %h", i, qq, vq[i]); end
            tests++; if (dzz !== 1'b0) begin fails++; $display("FAIL basic%0d_dz got %b exp 0", i, dzz); end
            tests++; if (lat !== 8) begin fails++; $display("FAIL basic%0d_lat got %0d exp 8", i, lat); end
            @(posedge clk); #1;
            tests++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
                fails++; $display("FAIL basic%0d_handshake got vld=%b rdy=%b exp vld=0 rdy=1", i, ifc.out_valid, ifc.in_ready);
            end
        end
    endtask

    task automatic test_zero();
        logic [7:0] qq;
        logic       dzz;
        int         lat, acc_at;
        do_op(8'h00, 8'h53, 1'b0, qq, dzz, lat, acc_at);
        tests++; if (qq !== 8'h00) begin fails++; $display("FAIL zero_n_q got %h exp 00", qq); end
        tests++; if (dzz !== 1'b0) begin fails++; $display("FAIL zero_n_dz got %b exp 0", dzz); end
        @(posedge clk); #1;
        do_op(8'h7A, 8'h00, 1'b0, qq, dzz, lat, acc_at);
        tests++; if (qq !== 8'h00) begin fails++; $display("FAIL zero_d_q got %h exp 00", qq); end
        tests++; if (dzz !== 1'b1) begin fails++; $display("FAIL zero_d_dz got %b exp 1", dzz); end
        tests++; if (lat !== 8) begin fails++; $display("FAIL zero_d_lat got %0d exp 8", lat); end
        @(posedge clk); #1;
        // dz must clear again on the next nonzero divisor.
        do_op(8'h02, 8'h02, 1'b0, qq, dzz, lat, acc_at);
        tests++; if (dzz !== 1'b0 || qq !== 8'h01) begin fails++; $display("FAIL zero_recover got q=%h dz=%b exp q=01 dz=0", qq, dzz); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] qq;
        logic       dzz;
        int         lat, acc_at;
        int         bad;
        ifc.out_ready = 1'b0;
        do_op(8'h53, 8'h53, 1'b0, qq, dzz, lat, acc_at);
        tests++; if (qq !== 8'h01) begin fails++; $display("FAIL bp_q got %h exp 01", qq); end
        tests++; if (lat !== 8) begin fails++; $display("FAIL bp_lat got %0d exp 8", lat); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ifc.out_valid !== 1'b1 || ifc.q !== 8'h01 || ifc.in_ready !== 1'b0 || ifc.div_by_zero !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_vld got %b exp 0", ifc.out_valid); end
        tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %b exp 1", ifc.in_ready); end
        tests++; if (ifc.q !== 8'h01) begin fails++; $display("FAIL bp_q_held_idle got %h exp 01", ifc.q); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] qq;
        logic       dzz;
        int         lat, acc_at;
        bit         seen;
        ifc.n = 8'h01;
        ifc.d = 8'h02;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;           // E0
        ifc.in_valid = 1'b0;
        repeat (3) @(posedge clk);    // E1..E3
        @(posedge clk); #1;           // E4
        rst_n = 1'b0;
        #1;
        tests++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_hs got rdy=%b vld=%b exp rdy=1 vld=0", ifc.in_ready, ifc.out_valid);
        end
        tests++; if (ifc.q !== 8'h00 || ifc.div_by_zero !== 1'b0) begin
            fails++; $display("FAIL midrst_out got q=%h dz=%b exp q=00 dz=0", ifc.q, ifc.div_by_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ifc.out_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_pulse got out_valid pulse exp none"); end
        do_op(8'h02, 8'h02, 1'b0, qq, dzz, lat, acc_at);
        tests++; if (qq !== 8'h01 || lat !== 8) begin fails++; $display("FAIL midrst_fresh got q=%h lat=%0d exp q=01 lat=8", qq, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive();
        logic [7:0] qq;
        logic       dzz;
        logic [7:0] nn;
        int         lat, acc_at, prev_at;
        ifc.out_ready = 1'b1;
        prev_at = -1;
        for (int dv = 1; dv < 256; dv++) begin
            nn = 8'($urandom_range(0, 255));
            do_op(nn, 8'(dv), 1'b0, qq, dzz, lat, acc_at);
            tests++; if (ref_mul(qq, 8'(dv)) !== nn || dzz !== 1'b0) begin
                fails++; $display("FAIL exh_d%02h got q=%h dz=%b (q*d=%h) exp q*d=%h dz=0", dv[7:0], qq, dzz, ref_mul(qq, 8'(dv)), nn);
            end
            if (prev_at >= 0) begin
                tests++; if (acc_at - prev_at !== 10) begin
                    fails++; $display("FAIL exh_spacing_d%02h got %0d exp 10", dv[7:0], acc_at - prev_at);
                end
            end
            prev_at = acc_at;
            @(posedge clk); #1;       // output handshake edge
        end
    endtask

    initial begin
        cyc   = 0;
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
